// File: rtl/pipe_mem_stage.sv
// Memory-access stage with MEM/WB register.
// Runs loads/stores over a req/ack bus and stalls upstream while busy.
module pipe_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        M_RegWrite,
  input  logic        M_M2Reg,
  input  logic        M_MemWrite,
  input  logic [31:0] M_result,
  input  logic [31:0] M_b,
  input  logic [4:0]  M_TargetReg,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        WB_RegWrite,
  output logic        WB_M2Reg,
  output logic [31:0] WB_result,
  output logic [31:0] WB_mem_data,
  output logic [4:0]  WB_TargetReg,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic       access;
  logic       aligned;
  logic       is_load;
  logic       start;
  logic       tmo;

  assign access  = M_M2Reg | M_MemWrite;
  assign aligned = (M_result[1:0] == 2'b00);
  // A store with M2Reg also set is still a store.
  assign is_load = M_M2Reg & ~M_MemWrite;
  assign start   = (state == IDLE) & access & aligned;
  assign tmo     = (state == BUS) & ~mem_ack
                 & (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = BUS;
      BUS:  if (mem_ack | tmo) state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall = start | ((state == BUS) & ~mem_ack & ~tmo);
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      cnt          <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      WB_RegWrite  <= 1'b0;
      WB_M2Reg     <= 1'b0;
      WB_result    <= '0;
      WB_mem_data  <= '0;
      WB_TargetReg <= '0;
      misalign     <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mem_req     <= 1'b1;
            mem_we      <= M_MemWrite;
            mem_addr    <= M_result;
            mem_wdata   <= M_b;
            cnt         <= '0;
            WB_RegWrite <= 1'b0;
            WB_M2Reg    <= 1'b0;
          end else begin
            WB_RegWrite  <= M_RegWrite & ~access;
            WB_M2Reg     <= is_load;
            WB_result    <= M_result;
            WB_TargetReg <= M_TargetReg;
            WB_mem_data  <= '0;
            misalign     <= access;
          end
        end
        BUS: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            WB_RegWrite  <= M_RegWrite;
            WB_M2Reg     <= is_load;
            WB_result    <= M_result;
            WB_TargetReg <= M_TargetReg;
            WB_mem_data  <= is_load ? mem_rdata : 32'h0;
          end else if (tmo) begin
            mem_req      <= 1'b0;
            bus_err      <= 1'b1;
            WB_RegWrite  <= 1'b0;
            WB_M2Reg     <= is_load;
            WB_result    <= M_result;
            WB_TargetReg <= M_TargetReg;
            WB_mem_data  <= '0;
          end else begin
            cnt         <= cnt + 8'd1;
            WB_RegWrite <= 1'b0;
            WB_M2Reg    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Bench for pipe_mem_stage: directed scenarios plus random
// instruction stream checked against a per-transaction model.
module tb_pipe_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        clrn;
  logic        M_RegWrite, M_M2Reg, M_MemWrite;
  logic [31:0] M_result, M_b;
  logic [4:0]  M_TargetReg;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        WB_RegWrite, WB_M2Reg;
  logic [31:0] WB_result, WB_mem_data;
  logic [4:0]  WB_TargetReg;
  logic        misalign, bus_err;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .clrn(clrn),
    .M_RegWrite(M_RegWrite), .M_M2Reg(M_M2Reg),
    .M_MemWrite(M_MemWrite), .M_result(M_result),
    .M_b(M_b), .M_TargetReg(M_TargetReg),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .WB_RegWrite(WB_RegWrite), .WB_M2Reg(WB_M2Reg),
    .WB_result(WB_result), .WB_mem_data(WB_mem_data),
    .WB_TargetReg(WB_TargetReg),
    .misalign(misalign), .bus_err(bus_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected behaviour of one instruction, from the stage's rules:
  // ackdel = BUS cycle index carrying the ack; >= TO means no ack.
  task automatic do_instr(input logic rw, input logic m2r,
                          input logic mw,
                          input logic [31:0] res,
                          input logic [31:0] b,
                          input logic [4:0] tr,
                          input int ackdel,
                          input logic [31:0] rdata);
    logic acc, algn, ld, done;
    logic [31:0] prev_res;
    acc  = m2r | mw;
    algn = (res[1:0] == 2'b00);
    ld   = m2r & ~mw;
    prev_res = WB_result;
    M_RegWrite = rw; M_M2Reg = m2r; M_MemWrite = mw;
    M_result = res; M_b = b; M_TargetReg = tr;
    mem_ack = 1'b0;
    #1;
    chk("stall_first", stall, acc && algn);
    if (!(acc && algn)) begin
      step();
      chk("wb_rw", WB_RegWrite, rw && !acc);
      chk("wb_m2r", WB_M2Reg, ld);
      chk("wb_res", WB_result, res);
      chk("wb_tr", WB_TargetReg, tr);
      chk("wb_mdata", WB_mem_data, 0);
      chk("misalign", misalign, acc);
      chk("req_idle", mem_req, 0);
      chk("buserr_idle", bus_err, 0);
      return;
    end
    step();
    chk("req_start", mem_req, 1);
    chk("we_start", mem_we, mw);
    chk("addr_start", mem_addr, res);
    chk("wdata_start", mem_wdata, b);
    chk("wb_bubble", WB_RegWrite, 0);
    chk("wb_m2r_bubble", WB_M2Reg, 0);
    chk("wb_res_hold", WB_result, prev_res);
    chk("misalign_low", misalign, 0);
    done = 1'b0;
    for (int i = 0; i < TO && !done; i++) begin
      mem_ack   = (i == ackdel);
      mem_rdata = mem_ack ? rdata : $urandom;
      #1;
      chk("stall_bus", stall, !(mem_ack || i == TO - 1));
      chk("req_bus", mem_req, 1);
      chk("addr_bus", mem_addr, res);
      chk("we_bus", mem_we, mw);
      step();
      if (i == ackdel) begin
        done = 1'b1;
        chk("req_done", mem_req, 0);
        chk("buserr_ack", bus_err, 0);
        chk("wb_rw_ack", WB_RegWrite, rw);
        chk("wb_m2r_ack", WB_M2Reg, ld);
        chk("wb_res_ack", WB_result, res);
        chk("wb_tr_ack", WB_TargetReg, tr);
        chk("wb_mdata_ack", WB_mem_data, ld ? rdata : 32'h0);
      end else if (i == TO - 1) begin
        done = 1'b1;
        chk("req_tmo", mem_req, 0);
        chk("buserr_tmo", bus_err, 1);
        chk("wb_rw_tmo", WB_RegWrite, 0);
        chk("wb_res_tmo", WB_result, res);
        chk("wb_tr_tmo", WB_TargetReg, tr);
      end else begin
        chk("wb_rw_wait", WB_RegWrite, 0);
        chk("buserr_wait", bus_err, 0);
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    clrn = 1'b0;
    M_RegWrite = 0; M_M2Reg = 0; M_MemWrite = 0;
    M_result = 0; M_b = 0; M_TargetReg = 0;
    mem_ack = 0; mem_rdata = 0;
    step();
    step();
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wb_rw", WB_RegWrite, 0);
    chk("rst_wb_res", WB_result, 0);
    chk("rst_wb_tr", WB_TargetReg, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_buserr", bus_err, 0);
    chk("rst_stall", stall, 0);
    clrn = 1'b1;

    do_instr(1, 0, 0, 32'h55, 0, 5'd3, 0, 0);
    do_instr(1, 1, 0, 32'h100, 0, 5'd7, 2, 32'hDEAD_BEEF);
    do_instr(0, 0, 1, 32'h204, 32'h1234_5678, 5'd0, 0, 0);
    do_instr(1, 1, 0, 32'h102, 0, 5'd9, 0, 0);
    do_instr(1, 0, 0, 32'h77, 0, 5'd4, 0, 0);
    do_instr(1, 1, 0, 32'h300, 0, 5'd5, TO, 0);
    do_instr(1, 1, 0, 32'h304, 0, 5'd6, TO - 1, 32'hCAFE_0001);
    do_instr(1, 1, 1, 32'h308, 32'hAA, 5'd8, 1, 32'h5555);

    // Spurious ack in IDLE with a plain ALU op.
    M_RegWrite = 1; M_M2Reg = 0; M_MemWrite = 0;
    M_result = 32'h99; M_TargetReg = 5'd2;
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("spur_stall", stall, 0);
    step();
    chk("spur_req", mem_req, 0);
    chk("spur_mdata", WB_mem_data, 0);
    chk("spur_res", WB_result, 32'h99);
    mem_ack = 0;

    // Reset while a load is outstanding.
    M_RegWrite = 1; M_M2Reg = 1; M_result = 32'h400;
    step();
    chk("mid_req", mem_req, 1);
    clrn = 0;
    M_RegWrite = 0; M_M2Reg = 0; M_MemWrite = 0;
    M_result = 0; M_b = 0; M_TargetReg = 0;
    step();
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_wb_rw", WB_RegWrite, 0);
    chk("mid_rst_wb_res", WB_result, 0);
    chk("mid_rst_wb_m2r", WB_M2Reg, 0);
    clrn = 1;
    mem_ack = 1; mem_rdata = 32'h1111_2222;
    #1;
    chk("late_ack_stall", stall, 0);
    step();
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_mdata", WB_mem_data, 0);
    chk("late_ack_buserr", bus_err, 0);
    mem_ack = 0;

    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      do_instr(1'($urandom), kind == 1 || kind == 3,
               kind == 2 || kind == 3, a, $urandom,
               5'($urandom), $urandom_range(0, TO), $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
